tppe_tile_scheduler: RTL and testbench

TPPE_TILE_SCHEDULER -- requirements
Module: tppe_tile_scheduler

---
 rtl/tppe_pkg.sv | 25 ++
 rtl/tppe_tile_fetch.sv | 135 +++++++++++++
 rtl/tppe_tile_scheduler.sv | 158 +++++++++++++++
 tb/tb_tppe_tile_scheduler.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tppe_pkg.sv
// Shared definitions for the TPPE tile scheduler: state encoding and default sizes.
// Latency: none (types, constants and a helper function only).
// Backpressure: not applicable.
package tppe_pkg;

  localparam int TPPE_T_WINDOW        = 16;
  localparam int TPPE_PARALLEL_FACTOR = 4;
  localparam int TPPE_NEURON_ID_W     = 4;
  localparam int TPPE_COL_ID_W        = 4;
  localparam int TPPE_GROUP_W         = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRIME = 3'd1,
    ST_RUN   = 3'd2,
    ST_STALL = 3'd3,
    ST_DRAIN = 3'd4
  } tppe_state_t;

  // Window counter width; kept at least one bit so a single-cycle window still elaborates.
  function automatic int tppe_cnt_w(input int t_window);
    return (t_window > 1) ? $clog2(t_window) : 1;
  endfunction

endpackage

// File: rtl/tppe_tile_fetch.sv
// Weight-tile fetcher: walks tiles neuron-major, keeps an active and a shadow tile buffer.
// Latency: request one cycle after launch or after the shadow empties; ack data usable in the ack cycle.
// Backpressure: holds wmem_req/addr until wmem_ack; only one request outstanding, only into an empty shadow.
module tppe_tile_fetch
  import tppe_pkg::*;
#(
  parameter int T_WINDOW        = TPPE_T_WINDOW,
  parameter int PARALLEL_FACTOR = TPPE_PARALLEL_FACTOR,
  parameter int NEURON_ID_W     = TPPE_NEURON_ID_W,
  parameter int COL_ID_W        = TPPE_COL_ID_W,
  parameter int GROUP_W         = TPPE_GROUP_W
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 launch,
  input  logic                                 swap,
  input  logic                                 flush,
  input  logic [NEURON_ID_W-1:0]               cfg_last_neuron,
  input  logic [GROUP_W-1:0]                   cfg_last_group,
  output logic                                 wmem_req,
  output logic [NEURON_ID_W+GROUP_W-1:0]       wmem_addr,
  input  logic                                 wmem_ack,
  input  logic [PARALLEL_FACTOR*T_WINDOW-1:0]  wmem_data,
  output logic                                 avail,
  output logic                                 pending,
  output logic [NEURON_ID_W-1:0]               act_neuron,
  output logic [COL_ID_W-1:0]                  act_col,
  output logic [PARALLEL_FACTOR*T_WINDOW-1:0]  act_pat
);

  localparam int PW = PARALLEL_FACTOR * T_WINDOW;

  typedef struct packed {
    logic [NEURON_ID_W-1:0] neuron;
    logic [GROUP_W-1:0]     group;
  } tile_id_t;

  localparam tile_id_t TILE0 = '0;

  tile_id_t        cur;        // tile of the current / most recent request
  tile_id_t        nxt;        // next tile to request
  tile_id_t        lim;        // latched last tile of the run
  tile_id_t        cfg_tile;
  logic            unfetched;  // tiles remain that have not been requested yet
  logic            sh_vld;
  tile_id_t        sh_id;
  logic [PW-1:0]   sh_pat;
  logic            data_now;
  logic            sh_vld_n;
  logic            issue;

  // Neuron-major successor: step the group, wrap into the next neuron after the last group.
  function automatic tile_id_t next_tile(input tile_id_t t, input tile_id_t l);
    tile_id_t n;
    n = t;
    if (t.group == l.group) begin
      n.neuron = t.neuron + NEURON_ID_W'(1);
      n.group  = '0;
    end else begin
      n.group = t.group + GROUP_W'(1);
    end
    return n;
  endfunction

  function automatic logic [COL_ID_W-1:0] col_of(input logic [GROUP_W-1:0] g);
    return COL_ID_W'(32'(g) * PARALLEL_FACTOR);
  endfunction

  assign wmem_addr = {cur.neuron, cur.group};
  assign avail     = sh_vld || data_now;
  assign pending   = wmem_req || unfetched;

  // Handshake decode: shadow occupancy after this edge decides whether a new fetch may go out.
  always_comb begin
    cfg_tile = '{neuron: cfg_last_neuron, group: cfg_last_group};
    data_now = wmem_req && wmem_ack;
    sh_vld_n = !swap && (sh_vld || data_now);
    issue    = unfetched && (!wmem_req || wmem_ack) && !sh_vld_n;
  end

  // Request generation and double-buffer update; an ack landing on a swap bypasses the shadow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wmem_req   <= 1'b0;
      cur        <= '0;
      nxt        <= '0;
      lim        <= '0;
      unfetched  <= 1'b0;
      sh_vld     <= 1'b0;
      sh_id      <= '0;
      sh_pat     <= '0;
      act_neuron <= '0;
      act_col    <= '0;
      act_pat    <= '0;
    end else if (launch) begin
      lim       <= cfg_tile;
      cur       <= TILE0;
      nxt       <= next_tile(TILE0, cfg_tile);
      unfetched <= (cfg_tile != TILE0);
      wmem_req  <= 1'b1;
      sh_vld    <= 1'b0;
    end else if (flush) begin
      // Aborting: forget queued work, keep the bus request up until the memory answers.
      sh_vld    <= 1'b0;
      unfetched <= 1'b0;
      if (wmem_ack) wmem_req <= 1'b0;
    end else begin
      if (swap) begin
        if (sh_vld) begin
          act_neuron <= sh_id.neuron;
          act_col    <= col_of(sh_id.group);
          act_pat    <= sh_pat;
        end else begin
          act_neuron <= cur.neuron;
          act_col    <= col_of(cur.group);
          act_pat    <= wmem_data;
        end
      end
      sh_vld <= sh_vld_n;
      if (data_now && !swap) begin
        sh_id  <= cur;
        sh_pat <= wmem_data;
      end
      if (issue) begin
        wmem_req  <= 1'b1;
        cur       <= nxt;
        nxt       <= next_tile(nxt, lim);
        unfetched <= (nxt != lim);
      end else if (data_now) begin
        wmem_req <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/tppe_tile_scheduler.sv
// TPPE tile scheduler: streams weight tiles into fixed-length scan windows, neuron-major order.
// Latency: request one cycle after start; window starts the cycle after its tile's ack, back-to-back when prefetched.
// Backpressure: stalls (enable low, tile held) while the next tile is still in flight; stop drains any open fetch.
module tppe_tile_scheduler
  import tppe_pkg::*;
#(
  parameter int T_WINDOW        = TPPE_T_WINDOW,
  parameter int PARALLEL_FACTOR = TPPE_PARALLEL_FACTOR,
  parameter int NEURON_ID_W     = TPPE_NEURON_ID_W,
  parameter int COL_ID_W        = TPPE_COL_ID_W,
  parameter int GROUP_W         = TPPE_GROUP_W
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic                                 stop,
  input  logic [NEURON_ID_W-1:0]               cfg_last_neuron,
  input  logic [GROUP_W-1:0]                   cfg_last_group,
  output logic                                 wmem_req,
  output logic [NEURON_ID_W+GROUP_W-1:0]       wmem_addr,
  input  logic                                 wmem_ack,
  input  logic [PARALLEL_FACTOR*T_WINDOW-1:0]  wmem_data,
  output logic                                 enable,
  output logic                                 weight_valid,
  output logic [NEURON_ID_W-1:0]               neuron_id,
  output logic [COL_ID_W-1:0]                  col_base,
  output logic [PARALLEL_FACTOR*T_WINDOW-1:0]  weight_patterns,
  output logic                                 scan_start,
  output logic                                 busy,
  output logic                                 done
);

  localparam int              CNT_W    = tppe_cnt_w(T_WINDOW);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(T_WINDOW - 1);

  tppe_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic             launch;
  logic             abort;
  logic             flush;
  logic             swap;
  logic             win_end;
  logic             avail;
  logic             pending;
  logic             outstanding;

  // Control decode shared by the FSM and the fetcher; stop always beats a swap.
  always_comb begin
    win_end     = (state == ST_RUN) && (cnt == CNT_LAST);
    launch      = (state == ST_IDLE) && start && !stop;
    abort       = stop && ((state == ST_PRIME) || (state == ST_RUN) || (state == ST_STALL));
    flush       = abort || (state == ST_DRAIN);
    swap        = !flush && avail &&
                  ((state == ST_PRIME) || (state == ST_STALL) || win_end);
    outstanding = wmem_req && !wmem_ack;
  end

  tppe_tile_fetch #(
    .T_WINDOW        (T_WINDOW),
    .PARALLEL_FACTOR (PARALLEL_FACTOR),
    .NEURON_ID_W     (NEURON_ID_W),
    .COL_ID_W        (COL_ID_W),
    .GROUP_W         (GROUP_W)
  ) u_fetch (
    .clk             (clk),
    .rst             (rst),
    .launch          (launch),
    .swap            (swap),
    .flush           (flush),
    .cfg_last_neuron (cfg_last_neuron),
    .cfg_last_group  (cfg_last_group),
    .wmem_req        (wmem_req),
    .wmem_addr       (wmem_addr),
    .wmem_ack        (wmem_ack),
    .wmem_data       (wmem_data),
    .avail           (avail),
    .pending         (pending),
    .act_neuron      (neuron_id),
    .act_col         (col_base),
    .act_pat         (weight_patterns)
  );

  // Run FSM with window counter; all drive qualifiers are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      enable       <= 1'b0;
      weight_valid <= 1'b0;
      scan_start   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      scan_start <= 1'b0;
      done       <= 1'b0;
      if (abort) begin
        enable       <= 1'b0;
        weight_valid <= 1'b0;
        cnt          <= '0;
        if (outstanding) begin
          state <= ST_DRAIN;
        end else begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      end else begin
        case (state)
          ST_IDLE: begin
            if (launch) begin
              state <= ST_PRIME;
              busy  <= 1'b1;
            end
          end
          ST_PRIME, ST_STALL: begin
            if (avail) begin
              state        <= ST_RUN;
              enable       <= 1'b1;
              weight_valid <= 1'b1;
              scan_start   <= 1'b1;
              cnt          <= '0;
            end
          end
          ST_RUN: begin
            if (win_end) begin
              cnt <= '0;
              if (avail) begin
                scan_start <= 1'b1;
              end else if (pending) begin
                state        <= ST_STALL;
                enable       <= 1'b0;
                weight_valid <= 1'b0;
              end else begin
                state        <= ST_IDLE;
                enable       <= 1'b0;
                weight_valid <= 1'b0;
                busy         <= 1'b0;
                done         <= 1'b1;
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          ST_DRAIN: begin
            if (!wmem_req || wmem_ack) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tppe_tile_scheduler.sv
// Bench for tppe_tile_scheduler: scenario table, hand sequences and random runs.
// Latency: expected timing comes from an event-time model of fetch, ack and window starts.
// Backpressure: a reactive memory model acks each request after a chosen latency.
module tb_tppe_tile_scheduler;

  localparam int T  = 16;
  localparam int PF = 4;
  localparam int NW = 4;
  localparam int CW = 4;
  localparam int GW = 2;
  localparam int PW = PF * T;
  localparam int AW = NW + GW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [NW-1:0] cfg_ln = '0;
  logic [GW-1:0] cfg_lg = '0;
  logic          wmem_req;
  logic [AW-1:0] wmem_addr;
  logic          wmem_ack = 1'b0;
  logic [PW-1:0] wmem_data = '0;
  logic          enable, weight_valid, scan_start, busy, done;
  logic [NW-1:0] neuron_id;
  logic [CW-1:0] col_base;
  logic [PW-1:0] weight_patterns;
  logic [83:0]   all_out;

  assign all_out = {busy, done, enable, weight_valid, scan_start, wmem_req,
                    wmem_addr, neuron_id, col_base, weight_patterns};

  tppe_tile_scheduler dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .stop            (stop),
    .cfg_last_neuron (cfg_ln),
    .cfg_last_group  (cfg_lg),
    .wmem_req        (wmem_req),
    .wmem_addr       (wmem_addr),
    .wmem_ack        (wmem_ack),
    .wmem_data       (wmem_data),
    .enable          (enable),
    .weight_valid    (weight_valid),
    .neuron_id       (neuron_id),
    .col_base        (col_base),
    .weight_patterns (weight_patterns),
    .scan_start      (scan_start),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Memory model state
  logic [PW-1:0] pat_mem [64];
  int  mem_lat [256];
  int  mem_fixed = 1;
  int  mem_idx   = 0;
  int  mem_cnt   = 0;
  int  cur_lat   = 0;
  bit  mem_new   = 1'b1;
  bit  force_ack = 1'b0;

  task automatic check(input string name, input int t, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, t, got, exp);
    end
  endtask

  // One memory cycle: a request is new if the previous cycle had no request or was acked.
  task automatic mem_step();
    wmem_ack  = 1'b0;
    wmem_data = {$urandom, $urandom};
    if (force_ack) begin
      wmem_ack = 1'b1;
    end else if (wmem_req) begin
      if (mem_new) begin
        mem_cnt = 0;
        cur_lat = (mem_fixed >= 0) ? mem_fixed : mem_lat[mem_idx];
        if (mem_idx < 255) mem_idx++;
      end else begin
        mem_cnt++;
      end
      if (mem_cnt >= cur_lat) begin
        wmem_ack  = 1'b1;
        wmem_data = pat_mem[wmem_addr];
      end
    end
    mem_new = !wmem_req || wmem_ack;
  endtask

  task automatic tick();
    @(negedge clk);
    mem_step();
  endtask

  // Full scheduled run checked cycle by cycle. Model: request k goes out when window k-1
  // starts (tile 0: the cycle after start), its ack comes lat_k cycles later, and window k
  // starts at max(end of window k-1, ack + 1).
  task automatic run_sched(input int ln, input int lg, input int lat, input int restart_at,
                           output int o_win, output int o_en, output int o_stall,
                           output int o_first, output int o_done);
    int n, g1, fin, lt, rk, ak, sk, kreq, kact;
    int r[$];
    int a[$];
    int s[$];
    bit e_busy, e_req, e_en, e_scan, e_done;
    n  = (ln + 1) * (lg + 1);
    g1 = lg + 1;
    mem_fixed = lat;
    mem_idx   = 0;
    mem_new   = 1'b1;
    if (lat < 0) for (int k = 0; k < n; k++) mem_lat[k] = $urandom_range(0, 25);
    for (int k = 0; k < n; k++) begin
      rk = (k == 0) ? 1 : s[k-1];
      lt = (lat >= 0) ? lat : mem_lat[k];
      ak = rk + lt;
      sk = ak + 1;
      if (k > 0 && s[k-1] + T > sk) sk = s[k-1] + T;
      r.push_back(rk);
      a.push_back(ak);
      s.push_back(sk);
    end
    fin = s[n-1] + T;
    o_win = 0; o_en = 0; o_stall = 0; o_first = -1; o_done = -1;
    start  = 1'b1;
    cfg_ln = NW'(ln);
    cfg_lg = GW'(lg);
    for (int t = 1; t <= fin + 3; t++) begin
      tick();
      e_busy = (t < fin);
      e_done = (t == fin);
      e_req = 1'b0; e_en = 1'b0; e_scan = 1'b0; kreq = -1; kact = -1;
      for (int k = 0; k < n; k++) begin
        if (r[k] <= t && t <= a[k]) begin e_req = 1'b1; kreq = k; end
        if (s[k] <= t) kact = k;
        if (t >= s[k] && t < s[k] + T) e_en = 1'b1;
        if (t == s[k]) e_scan = 1'b1;
      end
      check("ctrl", t, 128'({busy, wmem_req, enable, weight_valid, scan_start, done}),
            128'({e_busy, e_req, e_en, e_en, e_scan, e_done}));
      if (e_req)
        check("addr", t, 128'(wmem_addr), 128'((kreq / g1) * (1 << GW) + (kreq % g1)));
      if (kact >= 0)
        check("tile", t, 128'({neuron_id, col_base, weight_patterns}),
              128'({NW'(kact / g1), CW'((kact % g1) * PF),
                    pat_mem[(kact / g1) * (1 << GW) + (kact % g1)]}));
      if (scan_start) o_win++;
      if (enable) begin
        o_en++;
        if (o_first < 0) o_first = t;
      end
      if (busy && !enable && o_first >= 0) o_stall++;
      if (done) o_done = t;
      start  = (t == restart_at);
      cfg_ln = NW'($urandom);
      cfg_lg = GW'($urandom);
    end
    start = 1'b0;
  endtask

  typedef struct {
    int ln, lg, lat, restart;
    int exp_win, exp_en, exp_stall, exp_first, exp_done;
  } vec_t;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl [6];
    int w, e, st, f, d, ln, lg;
    bit e_busy, e_req, e_en;

    // cfg / ack latency / restart pulse -> windows, enable cycles, stall cycles, first enable, done
    tbl[0] = '{1, 1,  1, -1,  4,  64,  0,  3,  67};  // back-to-back, 64 contiguous cycles
    tbl[1] = '{1, 1, 20, -1,  4,  64, 15, 22, 101};  // long latency, 5-cycle stall per later tile
    tbl[2] = '{0, 0,  3, 10,  1,  16,  0,  5,  21};  // single tile, start mid-window ignored
    tbl[3] = '{1, 1, 15, -1,  4,  64,  0, 17,  81};  // ack lands exactly on window end
    tbl[4] = '{2, 3,  0, -1, 12, 192,  0,  2, 194};  // zero-latency memory, 12 tiles
    tbl[5] = '{0, 2, 17, -1,  3,  48,  4, 19,  71};  // one neuron, three groups, 2-cycle stalls

    for (int i = 0; i < 64; i++) pat_mem[i] = {$urandom, $urandom};

    #1 rst = 1'b1;
    @(negedge clk);
    check("reset_outputs", 0, 128'(all_out), 128'(0));
    tick();
    rst = 1'b0;
    tick();
    check("idle_after_reset", 0, 128'(all_out), 128'(0));

    for (int i = 0; i < 6; i++) begin
      tick();
      run_sched(tbl[i].ln, tbl[i].lg, tbl[i].lat, tbl[i].restart, w, e, st, f, d);
      check("tbl_windows", i, 128'(w), 128'(tbl[i].exp_win));
      check("tbl_en_cycles", i, 128'(e), 128'(tbl[i].exp_en));
      check("tbl_stall_cycles", i, 128'(st), 128'(tbl[i].exp_stall));
      check("tbl_first_en", i, 128'(f), 128'(tbl[i].exp_first));
      check("tbl_done_cycle", i, 128'(d), 128'(tbl[i].exp_done));
    end

    // Stop at window cycle 5 while tile 1 is in flight: drain until its ack, no done.
    tick();
    mem_fixed = 20; mem_idx = 0; mem_new = 1'b1;
    start = 1'b1; cfg_ln = 1; cfg_lg = 1;
    for (int t = 1; t <= 50; t++) begin
      tick();
      e_busy = (t <= 42);
      e_req  = (t <= 42);
      e_en   = (t >= 22 && t <= 27);
      check("stop_drain", t, 128'({busy, wmem_req, enable, weight_valid, done}),
            128'({e_busy, e_req, e_en, e_en, 1'b0}));
      start = 1'b0;
      stop  = (t == 27);
    end
    stop = 1'b0;

    // start and stop together in IDLE: nothing happens.
    start = 1'b1; stop = 1'b1;
    for (int t = 1; t <= 3; t++) begin
      tick();
      start = 1'b0; stop = 1'b0;
      check("start_stop_idle", t, 128'({busy, wmem_req, enable}), 128'(0));
    end

    // Reset in the middle of a window, with a stale ack still asserted afterwards.
    tick();
    mem_fixed = 1; mem_idx = 0; mem_new = 1'b1;
    start = 1'b1; cfg_ln = 1; cfg_lg = 1;
    for (int t = 1; t <= 30; t++) begin
      tick();
      start = 1'b0;
    end
    check("pre_reset_running", 30, 128'({busy, enable}), 128'(2'b11));
    #2 rst = 1'b1; force_ack = 1'b1;
    #1 check("reset_mid_run", 30, 128'(all_out), 128'(0));
    tick();
    tick();
    rst = 1'b0;
    for (int t = 1; t <= 4; t++) begin
      tick();
      check("stale_ack_ignored", t, 128'({busy, wmem_req, enable, done}), 128'(0));
    end
    force_ack = 1'b0;
    tick();
    run_sched(1, 1, 1, -1, w, e, st, f, d);
    check("rerun_windows", 0, 128'(w), 128'(4));
    check("rerun_done", 0, 128'(d), 128'(67));

    // Random configurations and per-request latencies.
    for (int i = 0; i < 5; i++) begin
      ln = $urandom_range(0, 3);
      lg = $urandom_range(0, 3);
      tick();
      run_sched(ln, lg, -1, -1, w, e, st, f, d);
      check("rnd_windows", i, 128'(w), 128'((ln + 1) * (lg + 1)));
      check("rnd_en_cycles", i, 128'(e), 128'((ln + 1) * (lg + 1) * T));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
